// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code encodings and the request bundle used by
// the arbiter and the decode stage.
package alu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b1110;
   localparam logic [3:0] ALU_OR   = 4'b1100;
   localparam logic [3:0] ALU_XOR  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b0010;
   localparam logic [3:0] ALU_SRL  = 4'b1010;
   localparam logic [3:0] ALU_SRA  = 4'b1011;
   localparam logic [3:0] ALU_SLT  = 4'b0100;
   localparam logic [3:0] ALU_SLTU = 4'b0110;

   localparam int ALU_WIDTH = 32;

   typedef struct packed {
      logic [3:0]           op;
      logic [ALU_WIDTH-1:0] data1;
      logic [ALU_WIDTH-1:0] data2;
   } alu_req_t;

endpackage

// File: rtl/ALU.sv
// Purely combinational ALU. The zero flag always comes from the adder, which
// subtracts only for ALU_SUB and adds for every other op code.
module ALU
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   localparam int SH_W = $clog2(WIDTH);

   logic [WIDTH-1:0] addsub;
   logic [SH_W-1:0]  shamt;

   assign addsub = (op == ALU_SUB) ? a - b : a + b;
   assign zero   = (addsub == '0);
   assign shamt  = b[SH_W-1:0];

   always_comb begin
      // NOTE: default assignment first so no path through the case leaves
      // result unassigned, which would infer a latch.
      result = b;
      case (op)
         ALU_ADD, ALU_SUB: result = addsub;
         ALU_AND:          result = a & b;
         ALU_OR:           result = a | b;
         ALU_XOR:          result = a ^ b;
         ALU_SLL:          result = a << shamt;
         ALU_SRL:          result = a >> shamt;
         ALU_SRA:          result = $signed(a) >>> shamt;
         ALU_SLT:          result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU:         result = {{(WIDTH-1){1'b0}}, (a < b)};
         default:          result = b;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between the execute unit (0) and the
// address/auxiliary unit (1), each with a one-entry registered response buffer.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            req_valid,
   output logic [1:0]            req_ready,
   input  logic [1:0][3:0]       req_op,
   input  logic [1:0][WIDTH-1:0] req_data1,
   input  logic [1:0][WIDTH-1:0] req_data2,
   output logic [1:0]            resp_valid,
   input  logic [1:0]            resp_ready,
   output logic [1:0][WIDTH-1:0] resp_result,
   output logic [1:0]            resp_zero,
   output logic [1:0][CNT_W-1:0] grant_cnt
);

   typedef struct packed {
      logic [3:0]       op;
      logic [WIDTH-1:0] data1;
      logic [WIDTH-1:0] data2;
   } arb_req_t;

   logic             prio;
   logic [1:0]       eligible;
   logic [1:0]       grant;
   logic             sel_idx;
   arb_req_t         sel_req;
   logic [WIDTH-1:0] alu_result;
   logic             alu_zero;

   // A requester whose buffer is full and not draining this edge cannot be granted.
   always_comb begin
      eligible = req_valid & (~resp_valid | resp_ready);
      grant    = eligible;
      if (&eligible) begin
         grant = prio ? 2'b10 : 2'b01;
      end
   end

   assign req_ready = grant;
   assign sel_idx   = grant[1];

   always_comb begin
      sel_req.op    = req_op[sel_idx];
      sel_req.data1 = req_data1[sel_idx];
      sel_req.data2 = req_data2[sel_idx];
   end

   ALU #(
      .WIDTH (WIDTH)
   ) u_alu (
      .op     (sel_req.op),
      .a      (sel_req.data1),
      .b      (sel_req.data2),
      .result (alu_result),
      .zero   (alu_zero)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio        <= 1'b0;
         resp_valid  <= '0;
         resp_result <= '0;
         resp_zero   <= '0;
         grant_cnt   <= '0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (grant[k]) begin
               resp_valid[k]  <= 1'b1;
               resp_result[k] <= alu_result;
               resp_zero[k]   <= alu_zero;
               grant_cnt[k]   <= grant_cnt[k] + CNT_W'(1);
            end else if (resp_ready[k]) begin
               resp_valid[k]  <= 1'b0;
            end
         end
         // Priority passes to the other side after every acceptance.
         if (grant[0]) begin
            prio <= 1'b1;
         end else if (grant[1]) begin
            prio <= 1'b0;
         end
      end
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

- Shares one combinational ALU between two requesters (index 0 = execute unit, index 1 = address/auxiliary unit).
- Selects one request per cycle with round-robin priority, drives the selected operands into the ALU, and registers the result into a per-requester one-entry response buffer.
- Each side has its own valid/ready request and response handshake.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be a power of two ≥ 8.
- CNT_W, 32, width of per-requester grant counters.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  request valid, per requester.
- req_ready  out  2  request accepted this cycle when valid & ready.
- req_op  in  2×4  ALU operation code, per requester.
- req_data1  in  2×WIDTH  first operand, per requester.
- req_data2  in  2×WIDTH  second operand, per requester.
- resp_valid  out  2  result available, per requester.
- resp_ready  in  2  response consumed when valid & ready.
- resp_result  out  2×WIDTH  registered result, per requester.
- resp_zero  out  2  registered zero flag (add/sub result == 0), per requester.
- grant_cnt  out  2×CNT_W  number of accepted requests, per requester.

## Operation
- ALU op codes:
  - 0000 add, 0001 sub.
  - 1110 and, 1100 or, 1000 xor.
  - 0010 sll, 1010 srl, 1011 sra (shift amount = data2[log2(WIDTH)-1:0]).
  - 0100 slt, 0110 sltu (result is 0 or 1).
  - Any other code passes data2.
- Zero flag is computed from the add/sub path for every op.
- eligible[k] = req_valid[k] & (~resp_valid[k] | resp_ready[k]). A requester with a full, undrained buffer cannot be granted.
- Grant:
  - If only one requester is eligible, grant it.
  - If both are eligible, grant the requester indicated by priority pointer `prio`.
  - Otherwise grant none.
  - req_ready[k] = grant[k]; at most one bit of req_ready is set.
- The ALU input mux selects the granted requester's op/data1/data2. The ALU output is captured into resp_result[k]/resp_zero[k] on the handshake edge, and resp_valid[k] is set.
- Priority update: after an accepted request from k, `prio` becomes 1-k. With no acceptance, `prio` holds.
- Response buffer k:
  - Set on acceptance.
  - Cleared on resp_valid & resp_ready unless a new acceptance for k occurs the same cycle, in which case it reloads and stays valid.
  - Data and zero flag are stable while resp_valid & ~resp_ready.
- grant_cnt[k] increments on each acceptance for k and wraps modulo 2^CNT_W.
- The arbiter never reorders within one requester, and at most one result per requester is outstanding.

## Timing
- Reset values: resp_valid = 0, resp_result = 0, resp_zero = 0, grant_cnt = 0, prio = 0. req_ready is combinational and 0 while req_valid = 0.
- req_ready is combinational from req_valid, resp_valid, resp_ready and prio. There is no combinational path from req_op/req_data to req_ready.
- Latency: a request accepted on edge N has resp_valid = 1 with the result after edge N (visible in cycle N+1).
- Throughput:
  - One result per cycle overall.
  - A single requester with resp_ready held high sustains one request per cycle (drain and reload on the same edge).
- Simultaneous valid from both requesters with both eligible alternates grants every cycle: 0,1,0,1… starting from the current prio.
- Reset asserted mid-operation: all buffers are invalidated immediately (asynchronous) and pending results are lost. After release the arbiter starts with prio = 0.
- Requesters must hold req_valid and operands stable until accepted. The arbiter does not check this.

## Structure
- Shared package `alu_pkg`: the ALU op-code localparams (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU) and a `alu_req_t` struct {op, data1, data2}. The arbiter and the decode stage both use these.
- One sub-module: the existing `ALU` (WIDTH passed through), instantiated once and fed by the grant mux. The arbitration and grant logic stays inline.

## Test plan
1. **Reset and single add:** reset, then req_valid=01, op 0000, 5+7 → req_ready=01 that cycle; next cycle resp_valid[0]=1, result 12, zero 0; grant_cnt[0]=1.
2. **Contention:** both valid every cycle, resp_ready=11, ops sub 3−3 (req 0) and sltu 1<2 (req 1) → grants 0,1,0,1; req 0 result 0 with zero=1; req 1 result 1.
3. **Backpressure:** resp_ready[0]=0 with resp_valid[0]=1 and req 0 still valid → req 0 never granted. Req 1 sra 0x80000000>>>4 is granted each cycle and yields 0xF8000000. Raising resp_ready[0] grants req 0 the same cycle.
4. **Drain and reload same edge:** req 0 streams xor ops with resp_ready[0]=1 → resp_valid[0] stays high and a new result appears every cycle.
5. **Async reset mid-flight:** drop rst_n between edges while resp_valid=11 → resp_valid=00 immediately; after release the first contended grant goes to req 0.
6. **Counter wrap:** with CNT_W=4, 17 accepted requests from req 1 → grant_cnt[1]=1.
